// File: rtl/mult_display_pkg.sv
// Shared constants for the multiplexed 7-segment display path: segment codes,
// idle patterns, default digit dwell time and the digit-index-to-anode mapping.
package mult_display_pkg;

    localparam int DIGIT_CYCLES_DEFAULT = 416_666;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] SEL_OFF = 4'b1111;

    typedef enum logic [1:0] {
        DIGIT_0 = 2'd0,
        DIGIT_1 = 2'd1,
        DIGIT_2 = 2'd2,
        DIGIT_3 = 2'd3
    } digit_e;

    // Exactly one active-low anode; bit 0 is the rightmost digit.
    function automatic logic [3:0] anode_sel(input digit_e idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/mult_display_seg7_decoder.sv
// BCD digit to active-low 7-segment code; codes 10-15 and the blank flag
// both produce a dark digit.
module seg7_decoder
    import mult_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/mult_display_top.sv
// Board-level display top: synchronizes the DIP operand, converts it to decimal
// and scans four common-anode digits. Define SIGNED_INPUT_EN for two's complement input.
module mult_display_top
    import mult_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dipswitch,
    output logic [6:0] segments,
    output logic [3:0] display_select,
    output logic       sign
);

    localparam int            CW       = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [CW-1:0] r_cnt;
    digit_e        r_idx;

    logic       w_neg;
    logic [3:0] w_mag;
    logic       w_tens;
    logic [3:0] w_ones;
    logic [3:0] w_bcd;
    logic       w_blank;
    logic [6:0] w_seg;

`ifdef SIGNED_INPUT_EN
    // Negating 1000 wraps back to 1000, which reads correctly as magnitude 8.
    assign w_neg = r_sync2[3];
    assign w_mag = w_neg ? (4'd0 - r_sync2) : r_sync2;
`else
    assign w_neg = 1'b0;
    assign w_mag = r_sync2;
`endif

    assign w_tens = (w_mag >= 4'd10);
    assign w_ones = w_tens ? (w_mag - 4'd10) : w_mag;

    always_comb begin
        w_bcd   = 4'd0;
        w_blank = 1'b1;
        case (r_idx)
            DIGIT_0: begin
                w_bcd   = w_ones;
                w_blank = 1'b0;
            end
            DIGIT_1: begin
                w_bcd   = {3'b000, w_tens};
                w_blank = !w_tens;
            end
            default: ;
        endcase
    end

    seg7_decoder u_dec (
        .i_bcd   (w_bcd),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // Anodes and segments both register from the current index, so they
    // always switch together on the edge after the counter wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_cnt          <= '0;
            r_idx          <= DIGIT_0;
            segments       <= SEG_OFF;
            display_select <= SEL_OFF;
            sign           <= 1'b0;
        end else begin
            r_sync1 <= dipswitch;
            r_sync2 <= r_sync1;
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= digit_e'(r_idx + 2'd1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            display_select <= anode_sel(r_idx);
            segments       <= w_seg;
            sign           <= w_neg;
        end
    end

endmodule

// File: tb/tb_mult_display_top.sv
// Directed bench for mult_display_top with DIGIT_CYCLES = 4; every cycle's
// expected {display_select, segments, sign} is queued and checked at the negedge.
`timescale 1ns/1ps
module tb_mult_display_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dipswitch = 4'b0000;
    logic [6:0] segments;
    logic [3:0] display_select;
    logic       sign;

    mult_display_top #(.DIGIT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dipswitch      (dipswitch),
        .segments       (segments),
        .display_select (display_select),
        .sign           (sign)
    );

    always #5 clk = ~clk;

    logic [11:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    logic [6:0] ones_tab [0:15];
    logic [6:0] tens_tab [0:15];
    logic       sign_tab [0:15];
    logic [3:0] sel_tab  [0:3];

    int         k  = 0;        // rising edges since reset release
    logic [3:0] d1 = 4'b0000;  // dipswitch seen at edge k-1
    logic [3:0] d2 = 4'b0000;  // dipswitch seen at edge k-2
    logic [3:0] eff = 4'b0000;

    // One clock: account for the edge just taken, drive new inputs, queue the
    // response expected at the following negedge.
    task automatic step(input logic rst_v, input logic [3:0] dip_v);
        logic [11:0] e;
        int slot;
        @(posedge clk);
        #2;
        if (rst) begin
            k++;
            eff = d2;
            d2  = d1;
            d1  = dipswitch;
        end else begin
            k   = 0;
            d1  = 4'b0000;
            d2  = 4'b0000;
            eff = 4'b0000;
        end
        rst       = rst_v;
        dipswitch = dip_v;
        if (!rst_v || k == 0) begin
            e = {4'b1111, 7'b1111111, 1'b0};
        end else begin
            slot = ((k - 1) / 4) % 4;
            case (slot)
                0:       e = {sel_tab[0], ones_tab[eff], sign_tab[eff]};
                1:       e = {sel_tab[1], tens_tab[eff], sign_tab[eff]};
                default: e = {sel_tab[slot], 7'b1111111, sign_tab[eff]};
            endcase
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input logic rst_v, input logic [3:0] dip_v, input int n);
        for (int i = 0; i < n; i++) step(rst_v, dip_v);
    endtask

    // Monitor
    initial begin
        logic [11:0] got;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                got = {display_select, segments, sign};
                e   = exp_q.pop_front();
                tests_run++;
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL scan_out t=%0t k=%0d got sel=%b seg=%b sign=%b expected sel=%b seg=%b sign=%b",
                             $time, k, got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    // Driver
    initial begin
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef SIGNED_INPUT_EN
        ones_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
                     7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int i = 0; i < 16; i++) tens_tab[i] = 7'b1111111;
        for (int i = 0; i < 16; i++) sign_tab[i] = (i >= 8);
`else
        ones_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b0010000, 7'b1000000, 7'b1111001,
                     7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
        for (int i = 0; i < 16; i++) tens_tab[i] = (i >= 10) ? 7'b1111001 : 7'b1111111;
        for (int i = 0; i < 16; i++) sign_tab[i] = 1'b0;
`endif

        run(1'b0, 4'b0001, 3);
        run(1'b1, 4'b0001, 34);
        run(1'b1, 4'b1111, 32);
        run(1'b1, 4'b1000, 32);
        run(1'b1, 4'b0111, 20);

        // Change mid digit0 slot: align so the next edge starts digit0.
        run(1'b1, 4'b0010, 4);
        for (int i = 0; i < 16 && (k % 16) != 0; i++) step(1'b1, 4'b0010);
        run(1'b1, 4'b0100, 20);

        // Reset during the digit2 slot, then resume.
        for (int i = 0; i < 16 && (k % 16) != 9; i++) step(1'b1, 4'b0100);
        run(1'b0, 4'b0100, 3);
        run(1'b1, 4'b0100, 24);

        repeat (2) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
